// File: rtl/voice_mixer.sv
// Eight-voice sawtooth mixer: a single multiply/accumulate datapath is shared by
// all voices, one voice per clock, producing one signed 16-bit PCM sample per sample_tick.
module voice_mixer #(
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned NUM_VOICES  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_tick,
  input  logic [31:0] frequencies   [NUM_VOICES],
  input  logic [31:0] voice_volumes [NUM_VOICES],
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

  localparam logic [63:0]        K       = (64'd1 << 44) / 64'(SAMPLE_RATE);
  localparam logic signed [31:0] VOL_ONE = 32'sd1 << 20;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_e;

  state_e             state_q, state_d;
  logic [2:0]         v_q, v_d;
  logic signed [18:0] acc_q, acc_d;
  logic [15:0]        sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic [31:0]        phase_q [NUM_VOICES];
  logic [31:0]        phase_d [NUM_VOICES];

  logic [31:0]        f_c;
  logic [63:0]        inc_full;
  logic [31:0]        inc;
  logic signed [31:0] vol_raw;
  logic signed [21:0] vol_c;
  logic signed [15:0] saw;
  logic signed [35:0] mul;
  logic signed [15:0] prod;

  // NOTE: combinational logic uses blocking '=' so each line sees the lines above it;
  // clocked state is only ever written with non-blocking '<='.
  always_comb begin
    f_c      = frequencies[v_q][31] ? 32'd0 : frequencies[v_q];
    inc_full = 64'(f_c) * K;
    inc      = 32'(inc_full >> 32);

    vol_raw = signed'(voice_volumes[v_q]);
    if (vol_raw < 0)            vol_c = '0;
    else if (vol_raw > VOL_ONE) vol_c = 22'(VOL_ONE);
    else                        vol_c = 22'(vol_raw);

    // The sawtooth is the top half of the phase before this frame's advance.
    saw  = signed'(phase_q[v_q][31:16]);
    mul  = 36'(saw) * 36'(vol_c);
    prod = 16'(mul >>> 20);
  end

  // NOTE: every *_d is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    v_d            = v_q;
    acc_d          = acc_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    overrun_d      = overrun_q;
    phase_d        = phase_q;

    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          acc_d   = '0;
          v_d     = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d        = acc_q + 19'(prod);
        phase_d[v_q] = phase_q[v_q] + inc;
        if (v_q == 3'd7) state_d = OUTPUT;
        else             v_d     = v_q + 3'd1;
      end
      OUTPUT: begin
        sample_d       = acc_q[18:3];
        sample_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A tick that arrives mid-frame is dropped; the frame in flight is untouched.
    if (sample_tick && state_q != IDLE) overrun_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      v_q            <= '0;
      acc_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      // NOTE: the phase array is reset like any other register because every voice
      // must restart at phase 0, so it cannot be mapped onto a non-resettable RAM.
      phase_q        <= '{default: '0};
    end else begin
      state_q        <= state_d;
      v_q            <= v_d;
      acc_q          <= acc_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      phase_q        <= phase_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule
